// File: rtl/si_dac_seq_pkg.sv
// Shared sine-wave project definitions: serial DAC sequencer states and default geometry.
package si_dac_seq_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int LOAD_W_DEF = 1;
    localparam int GAP_W_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        GAP   = 2'd3
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/si_dac_seq.sv
// Serialises one accepted sample MSB-first to a DAC, then strobes soc and idles GAP_W cycles.
// Frame takes 1+DATA_W+LOAD_W+GAP_W cycles accept-to-accept; s_ready is high only in IDLE, nothing is queued.
module si_dac_seq
    import si_dac_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LOAD_W = LOAD_W_DEF,
    parameter int GAP_W  = GAP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              SI,
    output logic              SI_en,
    output logic              soc,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);

    localparam int CNT_W = $clog2(max3(DATA_W, LOAD_W, GAP_W) + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_W > 0) ? GAP_W - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              s_ready_q, s_ready_d;
    logic              si_q, si_d;
    logic              si_en_q, si_en_d;
    logic              soc_q, soc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    state_d = SHIFT;
                    cnt_d   = SHIFT_LAST;
                    sr_d    = s_data;
                end
            end
            SHIFT: begin
                // sr_q[MSB] is the bit on SI this cycle; shifting exposes the next one
                sr_d = {sr_q[DATA_W-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = LOAD;
                    cnt_d   = LOAD_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    if (GAP_W == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LAST;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered alongside it
        s_ready_d   = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        si_en_d     = (state_d == SHIFT);
        si_d        = si_en_d & sr_d[DATA_W-1];
        soc_d       = (state_d == LOAD);
        frame_cnt_d = frame_cnt_q + 16'(done_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            s_ready_q   <= 1'b0;
            si_q        <= 1'b0;
            si_en_q     <= 1'b0;
            soc_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            s_ready_q   <= s_ready_d;
            si_q        <= si_d;
            si_en_q     <= si_en_d;
            soc_q       <= soc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign SI        = si_q;
    assign SI_en     = si_en_q;
    assign soc       = soc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_si_dac_seq.sv
// Bench for si_dac_seq: two instances (default timing, and LOAD_W=3/GAP_W=0) against a cycle-offset model.
module tb_si_dac_seq;

    localparam int DW  = 12;
    localparam int LW0 = 1;
    localparam int GW0 = 2;
    localparam int LW1 = 3;
    localparam int GW1 = 0;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] sd0 = '0, sd1 = '0;
    logic          sv0 = 1'b0, sv1 = 1'b0;
    logic          rdy0, si0, en0, soc0, busy0, done0;
    logic          rdy1, si1, en1, soc1, busy1, done1;
    logic [15:0]   fc0, fc1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    si_dac_seq #(.DATA_W(DW), .LOAD_W(LW0), .GAP_W(GW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_data(sd0), .s_valid(sv0), .s_ready(rdy0),
        .SI(si0), .SI_en(en0), .soc(soc0), .busy(busy0), .done(done0), .frame_cnt(fc0)
    );

    si_dac_seq #(.DATA_W(DW), .LOAD_W(LW1), .GAP_W(GW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_data(sd1), .s_valid(sv1), .s_ready(rdy1),
        .SI(si1), .SI_en(en1), .soc(soc1), .busy(busy1), .done(done1), .frame_cnt(fc1)
    );

    // Reference model: mk = cycles since accept (-1 idle and ready, -2 idle just out of reset)
    int            mk[2]    = '{-2, -2};
    logic [DW-1:0] mdata[2] = '{'0, '0};
    logic          mdone[2] = '{1'b0, 1'b0};
    logic [15:0]   mfr[2]   = '{16'h0, 16'h0};
    logic [15:0]   mbase[2] = '{16'h0, 16'h0};
    int            cyc = 0;
    int            acc_cyc[$];
    logic          mv;
    logic [DW-1:0] md;

    function automatic int lw(input int i);
        return (i == 0) ? LW0 : LW1;
    endfunction

    function automatic int gw(input int i);
        return (i == 0) ? GW0 : GW1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mk[i] = -2; mdone[i] = 1'b0; mfr[i] = 16'h0;
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                mv = (i == 0) ? sv0 : sv1;
                md = (i == 0) ? sd0 : sd1;
                mdone[i] = (mk[i] == DW + lw(i) - 1);
                if (mdone[i]) mfr[i] = mfr[i] + 16'h1;
                if (mk[i] == -2) mk[i] = -1;
                else if (mk[i] == -1) begin
                    if (mv) begin
                        mk[i] = 0; mdata[i] = md;
                        if (i == 0) acc_cyc.push_back(cyc);
                    end
                end else if (mk[i] == DW + lw(i) + gw(i) - 1) mk[i] = -1;
                else mk[i] = mk[i] + 1;
            end
        end
    end

    // {frame_cnt, s_ready, busy, SI_en, SI, soc, done}
    function automatic logic [21:0] expv(input int i);
        int k;
        logic en, si, so, bz, rd;
        logic [15:0] f;
        k  = mk[i];
        bz = (k >= 0);
        en = (k >= 0) && (k < DW);
        si = en ? mdata[i][DW-1-k] : 1'b0;
        so = (k >= DW) && (k < DW + lw(i));
        rd = (k == -1);
        f  = mbase[i] + mfr[i];
        return {f, rd, bz, en, si, so, mdone[i]};
    endfunction

    function automatic logic [21:0] obs(input int i);
        if (i == 0) return {fc0, rdy0, busy0, en0, si0, soc0, done0};
        return {fc1, rdy1, busy1, en1, si1, soc1, done1};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; mbase[0] = 16'h0; mbase[1] = 16'h0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (obs(i) !== 22'h0) begin
                n_fail++; $display("FAIL reset_state dut%0d got %h exp %h", i, obs(i), 22'h0);
            end
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (obs(0) !== expv(0)) begin
            n_fail++; $display("FAIL rst_release got %h exp %h", obs(0), expv(0));
        end
        @(negedge clk);
        n_tests++;
        if (rdy0 !== 1'b1 || obs(0) !== expv(0)) begin
            n_fail++; $display("FAIL rdy_after_release got %h exp %h", obs(0), expv(0));
        end
    endtask

    task automatic test_a5c();
        logic [DW-1:0] pdata = '0;
        int nbits = 0;
        for (int t = 0; t < 40 && rdy0 !== 1'b1; t++) @(negedge clk);
        sd0 = 12'hA5C; sv0 = 1'b1;
        for (int c = 0; c < 1 + DW + LW0 + GW0; c++) begin
            @(negedge clk);
            sv0 = 1'b0;
            n_tests++;
            if (obs(0) !== expv(0)) begin
                n_fail++; $display("FAIL a5c c%0d got %h exp %h", c, obs(0), expv(0));
            end
            if (en0) begin pdata = {pdata[DW-2:0], si0}; nbits++; end
        end
        n_tests++;
        if (pdata !== 12'hA5C || nbits != 12) begin
            n_fail++; $display("FAIL a5c_pdata got %h/%0d exp a5c/12", pdata, nbits);
        end
    endtask

    task automatic test_back_to_back();
        int idle = 0;
        for (int t = 0; t < 40 && rdy0 !== 1'b1; t++) @(negedge clk);
        acc_cyc.delete();
        sd0 = 12'hFFF; sv0 = 1'b1;
        for (int c = 0; c < 2 * (1 + DW + LW0 + GW0); c++) begin
            @(negedge clk);
            n_tests++;
            if (obs(0) !== expv(0)) begin
                n_fail++; $display("FAIL b2b c%0d got %h exp %h", c, obs(0), expv(0));
            end
            if (!busy0 && acc_cyc.size() == 1) idle++;
            if (c == 0) sd0 = 12'h000;
            if (c == DW + LW0 + GW0 + 1) sv0 = 1'b0;
        end
        n_tests++;
        if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 1 + DW + LW0 + GW0) begin
            n_fail++; $display("FAIL b2b_period got n=%0d exp 2 accepts %0d apart", acc_cyc.size(), 1 + DW + LW0 + GW0);
        end
        n_tests++;
        if (idle != 1) begin
            n_fail++; $display("FAIL b2b_idle got %0d exp 1", idle);
        end
    endtask

    task automatic test_ignore_valid();
        for (int t = 0; t < 40 && rdy0 !== 1'b1; t++) @(negedge clk);
        sd0 = DW'($urandom); sv0 = 1'b1;
        for (int c = 0; c < 1 + DW + LW0 + GW0; c++) begin
            @(negedge clk);
            n_tests++;
            if (obs(0) !== expv(0)) begin
                n_fail++; $display("FAIL ignore c%0d got %h exp %h", c, obs(0), expv(0));
            end
            sv0 = (c >= 1 && c <= 6);
            sd0 = DW'($urandom);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int t = 0; t < 40 && rdy0 !== 1'b1; t++) @(negedge clk);
        sd0 = DW'($urandom); sv0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            sv0 = 1'b0;
        end
        rst_n = 1'b0; mbase[0] = 16'h0; mbase[1] = 16'h0;
        #1;
        n_tests++;
        if (obs(0) !== 22'h0 || obs(0) !== expv(0)) begin
            n_fail++; $display("FAIL mid_reset got %h exp %h", obs(0), 22'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rdy0 !== 1'b1 || fc0 !== 16'h0) begin
            n_fail++; $display("FAIL mid_reset_release got rdy=%b fc=%h exp rdy=1 fc=0", rdy0, fc0);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_tests++;
            if (obs(0) !== expv(0)) begin
                n_fail++; $display("FAIL mid_reset_after c%0d got %h exp %h", c, obs(0), expv(0));
            end
        end
    endtask

    task automatic test_wrap();
        int ndone = 0;
        for (int t = 0; t < 40 && rdy0 !== 1'b1; t++) @(negedge clk);
        force dut0.frame_cnt_q = 16'hFFFF;
        mbase[0] = 16'hFFFF - mfr[0];
        @(negedge clk);
        release dut0.frame_cnt_q;
        n_tests++;
        if (obs(0) !== expv(0)) begin
            n_fail++; $display("FAIL wrap_preload got %h exp %h", obs(0), expv(0));
        end
        sd0 = DW'($urandom); sv0 = 1'b1;
        for (int c = 0; c < 1 + DW + LW0 + GW0; c++) begin
            @(negedge clk);
            sv0 = 1'b0;
            n_tests++;
            if (obs(0) !== expv(0)) begin
                n_fail++; $display("FAIL wrap c%0d got %h exp %h", c, obs(0), expv(0));
            end
            if (done0) begin
                ndone++;
                n_tests++;
                if (fc0 !== 16'h0000) begin
                    n_fail++; $display("FAIL wrap_cnt got %h exp 0000", fc0);
                end
            end
        end
        n_tests++;
        if (ndone != 1) begin
            n_fail++; $display("FAIL wrap_done got %0d pulses exp 1", ndone);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs(i) !== expv(i)) begin
                    n_fail++; $display("FAIL random dut%0d c%0d got %h exp %h", i, c, obs(i), expv(i));
                end
            end
            sv0 = ($urandom_range(0, 3) == 0); sd0 = DW'($urandom);
            sv1 = ($urandom_range(0, 3) == 0); sd1 = DW'($urandom);
        end
        sv0 = 1'b0; sv1 = 1'b0;
    endtask

    task automatic test_load3_gap0();
        int nsoc = 0;
        int dc = -10;
        for (int t = 0; t < 40 && rdy1 !== 1'b1; t++) @(negedge clk);
        sd1 = DW'($urandom); sv1 = 1'b1;
        for (int c = 0; c < 2 + DW + LW1 + GW1; c++) begin
            @(negedge clk);
            sv1 = 1'b0;
            n_tests++;
            if (obs(1) !== expv(1)) begin
                n_fail++; $display("FAIL l3g0 c%0d got %h exp %h", c, obs(1), expv(1));
            end
            if (soc1) nsoc++;
            if (done1) dc = c;
            if (c == dc + 1) begin
                n_tests++;
                if (rdy1 !== 1'b1) begin
                    n_fail++; $display("FAIL l3g0_rdy got %b exp 1", rdy1);
                end
            end
        end
        n_tests++;
        if (nsoc != 3 || dc != DW + LW1) begin
            n_fail++; $display("FAIL l3g0_soc got soc=%0d done@%0d exp soc=3 done@%0d", nsoc, dc, DW + LW1);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_reset_mid_frame();
        test_a5c();
        test_back_to_back();
        test_ignore_valid();
        test_load3_gap0();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
